mips_multicycle_control: RTL

Multi-cycle control unit that sits directly upstream of the single-cycle `Datapath` and drives its register-file, ALU and data-memory control inputs. It accepts one instruction's opcode/funct fields through a valid/ready handshake and sequences it through DECODE, EXECUTE, MEMORY and WRITEBACK states. For each state it asserts the matching Datapath control strobes and reports completion, branch decisions and illegal instructions. A retired-instruction counter is included for bring-up.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/mips_alu_decoder.sv | 42 ++++
 rtl/mips_multicycle_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct codes,
// ALU control codes, FSM state codes and the instruction-class decode.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_LW    = 3'd1,
        CLS_SW    = 3'd2,
        CLS_BEQ   = 3'd3,
        CLS_ADDI  = 3'd4,
        CLS_BAD   = 3'd5
    } instr_class_t;

    function automatic instr_class_t classify(input logic [5:0] opcode);
        instr_class_t cls;
        case (opcode)
            OP_RTYPE: cls = CLS_RTYPE;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BEQ:   cls = CLS_BEQ;
            OP_ADDI:  cls = CLS_ADDI;
            default:  cls = CLS_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps an instruction class and funct field to a 3-bit ALU code; the valid
// flag is low for any combination the datapath cannot execute.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  instr_class_t instr_class,
    input  logic [5:0]   funct,
    output logic [2:0]   alu_code,
    output logic         alu_valid
);

    // ALU operation lookup
    always_comb begin
        alu_code  = ALU_AND;
        alu_valid = 1'b0;
        case (instr_class)
            CLS_RTYPE: begin
                case (funct)
                    FN_ADD: begin alu_code = ALU_ADD; alu_valid = 1'b1; end
                    FN_SUB: begin alu_code = ALU_SUB; alu_valid = 1'b1; end
                    FN_AND: begin alu_code = ALU_AND; alu_valid = 1'b1; end
                    FN_OR:  begin alu_code = ALU_OR;  alu_valid = 1'b1; end
                    FN_SLT: begin alu_code = ALU_SLT; alu_valid = 1'b1; end
                    default: begin alu_code = ALU_AND; alu_valid = 1'b0; end
                endcase
            end
            CLS_LW, CLS_SW, CLS_ADDI: begin
                alu_code  = ALU_ADD;
                alu_valid = 1'b1;
            end
            CLS_BEQ: begin
                alu_code  = ALU_SUB;
                alu_valid = 1'b1;
            end
            default: begin
                alu_code  = ALU_AND;
                alu_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle control FSM driving the single-cycle Datapath strobes, with an
// instruction latch and a retired-instruction counter.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_instr_valid,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    output logic             o_instr_ready,
    output logic             o_regDst,
    output logic             o_ReadWriteRF,
    output logic             o_AluSource,
    output logic [2:0]       o_AluControl,
    output logic             o_MemToReg,
    output logic             o_WriteEnDataMemory,
    output logic             o_ReadEnDataMemory,
    output logic             o_branch_taken,
    output logic             o_done,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired
);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [5:0]       opcode_r;
    logic [5:0]       funct_r;
    instr_class_t     class_s;
    logic [2:0]       alu_code_s;
    logic             alu_valid_s;
    logic             accept_s;
    logic             done_s;
    logic [CNT_W-1:0] retired_r;

    assign class_s  = classify(opcode_r);
    assign accept_s = (state_r == ST_IDLE) && i_instr_valid;

    mips_alu_decoder u_alu_decoder (
        .instr_class (class_s),
        .funct       (funct_r),
        .alu_code    (alu_code_s),
        .alu_valid   (alu_valid_s)
    );

    // Next-state sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_instr_valid) state_nxt_s = ST_DECODE;
                else               state_nxt_s = ST_IDLE;
            end
            ST_DECODE: begin
                if (alu_valid_s) state_nxt_s = ST_EXEC;
                else             state_nxt_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (class_s == CLS_BEQ)                             state_nxt_s = ST_IDLE;
                else if ((class_s == CLS_LW) || (class_s == CLS_SW)) state_nxt_s = ST_MEM;
                else                                                 state_nxt_s = ST_WB;
            end
            ST_MEM: begin
                if (class_s == CLS_LW) state_nxt_s = ST_WB;
                else                   state_nxt_s = ST_IDLE;
            end
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and instruction latch; fields only captured on accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            opcode_r <= 6'd0;
            funct_r  <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                opcode_r <= i_opcode;
                funct_r  <= i_funct;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at full scale
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (done_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Moore strobe decode; ALU selects hold from EXEC through WB
    always_comb begin
        o_instr_ready       = 1'b0;
        o_regDst            = 1'b0;
        o_ReadWriteRF       = 1'b0;
        o_AluSource         = 1'b0;
        o_AluControl        = 3'b000;
        o_MemToReg          = 1'b0;
        o_WriteEnDataMemory = 1'b0;
        o_ReadEnDataMemory  = 1'b0;
        o_branch_taken      = 1'b0;
        done_s              = 1'b0;
        o_illegal           = 1'b0;
        if ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB)) begin
            o_AluControl = alu_code_s;
            o_AluSource  = (class_s == CLS_LW) || (class_s == CLS_SW) || (class_s == CLS_ADDI);
        end else begin
            o_AluControl = 3'b000;
            o_AluSource  = 1'b0;
        end
        case (state_r)
            ST_IDLE:   o_instr_ready = 1'b1;
            ST_DECODE: o_illegal = !alu_valid_s;
            ST_EXEC: begin
                if (class_s == CLS_BEQ) begin
                    o_branch_taken = i_zero;
                    done_s         = 1'b1;
                end else begin
                    o_branch_taken = 1'b0;
                    done_s         = 1'b0;
                end
            end
            ST_MEM: begin
                if (class_s == CLS_LW) begin
                    o_ReadEnDataMemory = 1'b1;
                end else begin
                    o_WriteEnDataMemory = 1'b1;
                    done_s              = 1'b1;
                end
            end
            ST_WB: begin
                o_ReadWriteRF = 1'b1;
                o_regDst      = (class_s == CLS_RTYPE);
                o_MemToReg    = (class_s == CLS_LW);
                done_s        = 1'b1;
            end
            default: o_instr_ready = 1'b0;
        endcase
    end

    assign o_done    = done_s;
    assign o_retired = retired_r;

endmodule
